// File: rtl/bubble_pkg.sv
// bubble_pkg: shared opcodes, function codes, FSM states and ALU operations for the BUBBLE processor
package bubble_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_MUL
    } alu_op_t;

endpackage

// File: rtl/bubble_alu.sv
// bubble_alu: combinational ALU; shifts act on b by shamt, slt is signed, mul keeps the low 32 bits
module bubble_alu
    import bubble_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);

    // select the operation result; zero flag drives beq/bne
    always_comb begin
        result = op == ALU_SUB ? a - b :
                 op == ALU_AND ? a & b :
                 op == ALU_OR  ? a | b :
                 op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} :
                 op == ALU_SLL ? b << shamt :
                 op == ALU_SRL ? b >> shamt :
                 op == ALU_MUL ? a * b :
                 a + b;
        zero = result == 32'b0;
    end

endmodule

// File: rtl/bubble_processor.sv
// bubble_processor: single-cycle MIPS-style core with serially loaded instruction/data memories.
// Define BUBBLE_MUL_EN to decode R-type funct 0x18 as mul; otherwise it is a NOP.
module bubble_processor
    import bubble_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_signal,
    input  logic [31:0] new_instruction,
    input  logic        add_into,
    output logic        end_signal
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    state_t        state;
    logic [IW-1:0] pc;
    logic [IW-1:0] iptr;
    logic [DW-1:0] dptr;
    logic [31:0]   rf   [32];
    logic [31:0]   imem [IMEM_DEPTH];
    logic [31:0]   dmem [DMEM_DEPTH];

    logic [31:0]   instr;
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [31:0]   sext;
    logic [31:0]   zext;
    logic [31:0]   rs_val;
    logic [31:0]   rt_val;

    alu_op_t       alu_op;
    logic [31:0]   alu_b;
    logic [31:0]   alu_res;
    logic          alu_zero;
    logic          wr_en;
    logic [4:0]    wr_dst;
    logic          mem_wr;
    logic          is_lw;
    logic          taken;
    logic [IW-1:0] pc_inc;
    logic [IW-1:0] pc_next;
    logic [DW-1:0] daddr;
    logic [31:0]   wdata;

    assign instr  = imem[pc];
    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign sext   = {{16{instr[15]}}, instr[15:0]};
    assign zext   = {16'b0, instr[15:0]};
    assign rs_val = rf[rs];
    assign rt_val = rf[rt];

    bubble_alu u_alu (
        .op     (alu_op),
        .a      (rs_val),
        .b      (alu_b),
        .shamt  (shamt),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // decode the current instruction into ALU, writeback and memory controls; unknown encodings stay NOPs
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rt_val;
        wr_en  = 1'b0;
        wr_dst = rd;
        mem_wr = 1'b0;
        is_lw  = 1'b0;
        case (op)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SLL:   alu_op = ALU_SLL;
                    F_SRL:   alu_op = ALU_SRL;
`ifdef BUBBLE_MUL_EN
                    F_MUL:   alu_op = ALU_MUL;
`endif
                    default: wr_en = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_b  = sext;
                wr_en  = 1'b1;
                wr_dst = rt;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                alu_b  = zext;
                wr_en  = 1'b1;
                wr_dst = rt;
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                alu_b  = zext;
                wr_en  = 1'b1;
                wr_dst = rt;
            end
            OP_LW: begin
                alu_b  = sext;
                wr_en  = 1'b1;
                wr_dst = rt;
                is_lw  = 1'b1;
            end
            OP_SW: begin
                alu_b  = sext;
                mem_wr = 1'b1;
            end
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            default: ;
        endcase
    end

    assign taken   = (op == OP_BEQ && alu_zero) || (op == OP_BNE && !alu_zero);
    assign pc_inc  = pc + IW'(1);
    assign pc_next = op == OP_J ? instr[IW-1:0] : taken ? pc_inc + sext[IW-1:0] : pc_inc;
    assign daddr   = alu_res[DW-1:0];
    assign wdata   = is_lw ? dmem[daddr] : alu_res;

    // LOAD/RUN/DONE control: serial memory fill, one instruction per clock, freeze on HALT
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_LOAD;
            pc         <= '0;
            iptr       <= '0;
            dptr       <= '0;
            end_signal <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (start_signal) begin
                        state <= ST_RUN;
                    end else if (add_into) begin
                        dmem[dptr] <= new_instruction;
                        dptr       <= dptr + DW'(1);
                    end else begin
                        imem[iptr] <= new_instruction;
                        iptr       <= iptr + IW'(1);
                    end
                end
                ST_RUN: begin
                    if (op == OP_HALT) begin
                        state      <= ST_DONE;
                        end_signal <= 1'b1;
                    end else begin
                        pc <= pc_next;
                        if (wr_en && wr_dst != 5'd0) rf[wr_dst] <= wdata;
                        if (mem_wr) dmem[daddr] <= rt_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_processor.sv
// tb_bubble_processor: directed and random programs checked against an instruction-level reference model
module tb_bubble_processor;

    localparam int DEPTH = 64;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_signal = 1'b0;
    logic [31:0] new_instruction = '0;
    logic        add_into = 1'b0;
    logic        end_signal;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_rf   [32];
    logic [31:0] m_imem [DEPTH];
    logic [31:0] m_dmem [DEPTH];
    int          m_pc;
    int          m_steps;
    int          m_iptr;
    int          m_dptr;

    bubble_processor #(.IMEM_DEPTH(DEPTH), .DMEM_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_signal    (start_signal),
        .new_instruction (new_instruction),
        .add_into        (add_into),
        .end_signal      (end_signal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input int f, input int s, input int t, input int d, input int sh);
        r_ins = {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(f)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int s, input int t, input int imm);
        i_ins = {6'(op), 5'(s), 5'(t), 16'(imm)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_signal = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_imem[i] = '0;
            m_dmem[i] = '0;
        end
        m_iptr = 0;
        m_dptr = 0;
    endtask

    task automatic load(input logic [31:0] w, input logic tgt);
        start_signal = 1'b0;
        add_into = tgt;
        new_instruction = w;
        tick();
        if (tgt) begin
            m_dmem[m_dptr] = w;
            m_dptr = (m_dptr + 1) % DEPTH;
        end else begin
            m_imem[m_iptr] = w;
            m_iptr = (m_iptr + 1) % DEPTH;
        end
    endtask

    // executes the loaded program instruction by instruction until HALT (or a step cap)
    task automatic model_run();
        logic [31:0] ins, a, b, se, res, addr;
        logic [5:0]  op, fn;
        int          dst;
        logic        wr;
        m_pc = 0;
        m_steps = 0;
        while (m_steps < 2000) begin
            ins = m_imem[m_pc];
            m_steps++;
            op = ins[31:26];
            fn = ins[5:0];
            if (op == 6'h3F) break;
            a = m_rf[ins[25:21]];
            b = m_rf[ins[20:16]];
            se = {{16{ins[15]}}, ins[15:0]};
            wr = 1'b1;
            dst = int'(ins[20:16]);
            res = '0;
            case (op)
                6'h00: begin
                    dst = int'(ins[15:11]);
                    case (fn)
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: res = b << ins[10:6];
                        6'h02: res = b >> ins[10:6];
`ifdef BUBBLE_MUL_EN
                        6'h18: res = a * b;
`endif
                        default: wr = 1'b0;
                    endcase
                end
                6'h08: res = a + se;
                6'h0C: res = a & {16'b0, ins[15:0]};
                6'h0D: res = a | {16'b0, ins[15:0]};
                6'h23: begin
                    addr = a + se;
                    res = m_dmem[addr % DEPTH];
                end
                default: wr = 1'b0;
            endcase
            if (op == 6'h2B) begin
                addr = a + se;
                m_dmem[addr % DEPTH] = b;
            end
            if (wr && dst != 0) m_rf[dst] = res;
            addr = 32'(m_pc) + 32'd1;
            if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) addr = addr + se;
            if (op == 6'h02) addr = ins;
            m_pc = int'(addr % DEPTH);
        end
    endtask

    // starts the DUT, counts edges until end_signal, then compares full architectural state
    task automatic run_and_check(input string tag);
        int n;
        model_run();
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        add_into = 1'b1;
        new_instruction = $urandom;
        n = 0;
        while (!end_signal && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(m_steps));
        for (int i = 0; i < 32; i++) check($sformatf("%s_rf%0d", tag, i), dut.rf[i], m_rf[i]);
        for (int i = 0; i < DEPTH; i++) check($sformatf("%s_dmem%0d", tag, i), dut.dmem[i], m_dmem[i]);
        repeat (3) tick();
        check({tag, "_pc_frozen"}, 32'(dut.pc), 32'(m_pc));
        check({tag, "_end_held"}, 32'(end_signal), 32'd1);
    endtask

    initial begin
        do_reset();
        check("reset_end", 32'(end_signal), 32'd0);
        check("reset_pc", 32'(dut.pc), 32'd0);

        load(i_ins(8, 0, 1, 5), 0);
        load(i_ins(8, 1, 2, 7), 0);
        load(HALT, 0);
        run_and_check("t1");
        check("t1_r2", dut.rf[2], 32'd12);
        check("t1_steps", 32'(m_steps), 32'd3);

        do_reset();
        load(i_ins(6'h23, 0, 1, 0), 0);
        load(i_ins(6'h23, 0, 2, 1), 0);
        load(r_ins(6'h20, 1, 2, 3, 0), 0);
        load(i_ins(6'h2B, 0, 3, 2), 0);
        load(HALT, 0);
        load(32'd10, 1);
        load(32'd20, 1);
        run_and_check("t2");
        check("t2_dmem2", dut.dmem[2], 32'd30);

        do_reset();
        load(i_ins(8, 0, 2, 4), 0);
        load(i_ins(8, 1, 1, 1), 0);
        load(i_ins(5, 1, 2, -2), 0);
        load(i_ins(4, 0, 0, 1), 0);
        load(i_ins(8, 0, 1, 99), 0);
        load(HALT, 0);
        run_and_check("t3");
        check("t3_r1", dut.rf[1], 32'd4);

        do_reset();
        load(i_ins(8, 0, 1, -1), 0);
        load(r_ins(6'h02, 0, 1, 2, 28), 0);
        load(r_ins(6'h2A, 1, 0, 3, 0), 0);
        load(i_ins(8, 0, 0, 9), 0);
        load(HALT, 0);
        run_and_check("t4");
        check("t4_r2", dut.rf[2], 32'd15);
        check("t4_r3", dut.rf[3], 32'd1);
        check("t4_r0", dut.rf[0], 32'd0);

        do_reset();
        load(i_ins(8, 5, 5, 1), 0);
        load(32'h0800_0000, 0);
        load(32'd77, 1);
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        repeat (10) tick();
        check("t5_running_r5", 32'(dut.rf[5] != 0), 32'd1);
        do_reset();
        check("t5_reset_r5", dut.rf[5], 32'd0);
        check("t5_reset_dmem0", dut.dmem[0], 32'd0);
        check("t5_reset_end", 32'(end_signal), 32'd0);
        load(i_ins(8, 0, 6, 21), 0);
        load(r_ins(6'h00, 0, 6, 7, 1), 0);
        load(HALT, 0);
        run_and_check("t5");
        check("t5_r7", dut.rf[7], 32'd42);

        do_reset();
        load(i_ins(8, 0, 1, -3), 0);
        load(i_ins(8, 0, 2, 7), 0);
        load(i_ins(8, 0, 3, 99), 0);
        load(r_ins(6'h18, 1, 2, 3, 0), 0);
        load(HALT, 0);
        run_and_check("t6");
`ifdef BUBBLE_MUL_EN
        check("t6_mul", dut.rf[3], 32'hFFFF_FFEB);
`else
        check("t6_mul", dut.rf[3], 32'd99);
`endif

        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < 24; i++) begin
                int s, t, d, sel;
                logic [31:0] w;
                s = $urandom_range(0, 7);
                t = $urandom_range(0, 7);
                d = $urandom_range(0, 7);
                sel = $urandom_range(0, 11);
                case (sel)
                    0: w = r_ins(6'h20, s, t, d, 0);
                    1: w = r_ins(6'h22, s, t, d, 0);
                    2: w = r_ins(6'h24, s, t, d, 0);
                    3: w = r_ins(6'h25, s, t, d, 0);
                    4: w = r_ins(6'h2A, s, t, d, 0);
                    5: w = r_ins(6'h00, s, t, d, $urandom_range(0, 31));
                    6: w = r_ins(6'h02, s, t, d, $urandom_range(0, 31));
                    7: w = i_ins(8, s, t, $urandom);
                    8: w = i_ins(6'h0C, s, t, $urandom);
                    9: w = i_ins(6'h0D, s, t, $urandom);
                    10: w = i_ins(6'h23, s, t, $urandom);
                    default: w = i_ins(6'h2B, s, t, $urandom);
                endcase
                load(w, 0);
            end
            load(HALT, 0);
            for (int i = 0; i < 8; i++) load($urandom, 1);
            run_and_check($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bubble_processor.md
Name: bubble_processor

Overview:
- 32-bit MIPS-style single-cycle processor with separate instruction and data memories, both filled serially through a shared input word before execution begins.
- Top-level compute block of the BUBBLE design.
- The bench loads the program, then loads data, raises start_signal, and watches end_signal.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of 2).
- DMEM_DEPTH, 64, data memory depth in 32-bit words (power of 2).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_signal  input  1  0 = loading phase, 1 = begin execution.
- new_instruction  input  32  word to store during the loading phase.
- add_into  input  1  load target: 0 = instruction memory, 1 = data memory.
- end_signal  output  1  high once a HALT has executed.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- State machine: LOAD -> RUN -> DONE.
- Reset, from any state including mid-run:
  - state=LOAD, PC=0, load pointers iptr=dptr=0.
  - All 32 registers = 0; both memories cleared to 0.
  - end_signal=0.
- LOAD, each rising edge with start_signal=0:
  - add_into=0: imem[iptr] <= new_instruction; iptr++.
  - add_into=1: dmem[dptr] <= new_instruction; dptr++.
  - Pointers wrap modulo depth.
- LOAD, edge with start_signal=1: no write; state -> RUN. The first instruction executes on the next edge.
- RUN:
  - start_signal is a latched trigger; deassertion is ignored. Loading inputs are ignored.
  - One instruction completes per clock. PC is a word index, wrapping modulo IMEM_DEPTH.
  - Unwritten words are 0, i.e. NOP (sll $0).
- ISA uses MIPS field layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0].
  - R-type (op 0), by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02 (by shamt).
  - I-type: addi 0x08 (sign-ext), andi 0x0C (zero-ext), ori 0x0D (zero-ext), lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - Jump: j 0x02.
  - HALT: op 0x3F.
- Arithmetic wraps modulo 2^32; no overflow traps.
- $0 reads 0; writes to $0 are discarded.
- lw/sw: word address = (rs + sext(imm)) mod DMEM_DEPTH.
- Branch taken: PC <= PC+1+sext(imm). Otherwise PC <= PC+1.
- j: PC <= target[25:0] mod IMEM_DEPTH.
- Unknown opcode or funct: NOP.
- HALT:
  - State -> DONE; end_signal=1 from that edge.
  - No further register or memory writes.
  - Remains in DONE until reset.

Optional Feature:
- BUBBLE_MUL_EN defined: R-type funct 0x18 (mul) writes the low 32 bits of the signed product rs*rt to rd.
- Undefined: funct 0x18 is a NOP.

Decomposition:
- Package bubble_pkg holds:
  - opcode/funct localparams;
  - state enum (LOAD/RUN/DONE);
  - ALU-op typedef.
- One natural sub-module: bubble_alu (combinational; op, a, b, shamt -> result, zero).
- Register file, memories, and control stay in bubble_processor.

Test Plan:
- Reset then load 3 instr (addi $1,$0,5; addi $2,$1,7; HALT), start -> end_signal rises 3 edges after RUN entry; $2=12.
- Load instr (lw $1,0($0); lw $2,1($0); add $3,$1,$2; sw $3,2($0); HALT), data {10,20} -> dmem[2]=30.
- beq/bne loop counting $1 from 0 to 4 then HALT -> $1=4; end_signal=1; PC frozen afterwards.
- addi $1,$0,-1; srl $2,$1,28; slt $3,$1,$0; addi $0,$0,9 -> $2=15, $3=1, $0=0.
- Assert reset mid-RUN, reload a new program -> old registers read 0; new program result correct; end_signal=0 until its HALT.
- With BUBBLE_MUL_EN: mul of -3 and 7 -> 0xFFFFFFEB. Without it: rd unchanged.
